// File: rtl/sprite_motion_pkg.sv
// Shared types and constants for the sprite motion engine.
package sprite_motion_pkg;

    typedef enum logic [1:0] {
        EDGE_BOUNCE = 2'd0,
        EDGE_WRAP   = 2'd1,
        EDGE_CLAMP  = 2'd2
    } edge_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        LOCK = 2'd2
    } motion_state_e;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;

    // EdgeHit bit positions: {B,T,R,L}
    localparam int EDGE_L = 0;
    localparam int EDGE_R = 1;
    localparam int EDGE_T = 2;
    localparam int EDGE_B = 3;

endpackage

// File: rtl/sprite_motion_if.sv
// Key/pause inputs and position/velocity/status outputs of one sprite.
interface sprite_motion_if #(
    parameter int W    = 10,
    parameter int NKEY = 2
);
    logic                   Pause;
    logic [8*NKEY-1:0]      keycode;
    logic [W-1:0]           BallX;
    logic [W-1:0]           BallY;
    logic [W-1:0]           BallS;
    logic signed [W-1:0]    VelX;
    logic signed [W-1:0]    VelY;
    logic [3:0]             EdgeHit;
    logic                   Locked;

    modport master (
        output Pause, keycode,
        input  BallX, BallY, BallS, VelX, VelY, EdgeHit, Locked
    );

    modport slave (
        input  Pause, keycode,
        output BallX, BallY, BallS, VelX, VelY, EdgeHit, Locked
    );
endinterface

// File: rtl/sprite_motion_key_dir_decode.sv
// Scans all keycode slots for WASD and reduces them to a signed direction per axis.
module key_dir_decode
    import sprite_motion_pkg::*;
#(
    parameter int NKEY = 2
) (
    input  logic [8*NKEY-1:0] keycode,
    output logic signed [1:0] dx,
    output logic signed [1:0] dy
);
    logic up, down, left, right;

    always_comb begin
        up    = 1'b0;
        down  = 1'b0;
        left  = 1'b0;
        right = 1'b0;
        for (int i = 0; i < NKEY; i++) begin
            if (keycode[8*i +: 8] == KEY_W) up    = 1'b1;
            if (keycode[8*i +: 8] == KEY_S) down  = 1'b1;
            if (keycode[8*i +: 8] == KEY_A) left  = 1'b1;
            if (keycode[8*i +: 8] == KEY_D) right = 1'b1;
        end
        // Opposing keys cancel naturally through the subtraction.
        dx = $signed({1'b0, right}) - $signed({1'b0, left});
        dy = $signed({1'b0, down})  - $signed({1'b0, up});
    end
endmodule

// File: rtl/sprite_motion.sv
// Per-frame position/velocity engine for one sprite: key decode, hold-to-accelerate,
// edge handling (bounce/wrap/clamp) and post-impact key lockout.
module sprite_motion
    import sprite_motion_pkg::*;
#(
    parameter int         W            = 10,
    parameter int         NKEY         = 2,
    parameter int         X_MIN        = 0,
    parameter int         X_MAX        = 639,
    parameter int         Y_MIN        = 0,
    parameter int         Y_MAX        = 479,
    parameter int         X_START      = 320,
    parameter int         Y_START      = 240,
    parameter int         SIZE         = 4,
    parameter int         STEP_INIT    = 1,
    parameter int         STEP_MAX     = 4,
    parameter int         ACCEL_FRAMES = 8,
    parameter edge_mode_e EDGE_MODE    = EDGE_BOUNCE,
    parameter int         LOCK_FRAMES  = 4
) (
    input logic             frame_clk,
    input logic             Reset_n,
    sprite_motion_if.slave  bus
);
    localparam int PW    = W + 2;
    localparam int F_SAT = ACCEL_FRAMES * (STEP_MAX - STEP_INIT);
    localparam int FW    = $clog2(F_SAT + 2);
    localparam int LW    = $clog2(LOCK_FRAMES + 2);

    typedef struct packed {
        logic [W-1:0]        pos;
        logic signed [W-1:0] vel;
        logic                lo;
        logic                hi;
    } axis_t;

    motion_state_e       state, state_next;
    logic [W-1:0]        pos_x, pos_y;
    logic signed [W-1:0] vel_x, vel_y, vnx, vny, spd;
    logic signed [1:0]   dx, dy, req_dx, req_dy, prev_dx, prev_dy;
    logic                req_nz, locked;
    logic [FW-1:0]       f_cnt, f_now;
    logic [LW-1:0]       lock_cnt, lock_next;
    logic [3:0]          edge_hit, hit;
    axis_t               rx, ry;

    function automatic logic signed [W-1:0] sat_speed(input logic [FW-1:0] f);
        int s;
        s = STEP_INIT + int'(f) / ACCEL_FRAMES;
        if (s > STEP_MAX) s = STEP_MAX;
        return W'(s);
    endfunction

    function automatic logic signed [W-1:0] scale(input logic signed [1:0] d,
                                                  input logic signed [W-1:0] s);
        case (d)
            2'sb01:  return s;
            2'sb11:  return -s;
            default: return '0;
        endcase
    endfunction

    // Candidate position is widened so overshoot past either bound stays representable.
    function automatic axis_t resolve_axis(input logic [W-1:0] pos,
                                           input logic signed [W-1:0] vel,
                                           input int lo_b, input int hi_b);
        axis_t             res;
        logic signed [PW-1:0] cand, lo, hi, span, sz;
        cand = $signed({2'b00, pos}) + $signed({{2{vel[W-1]}}, vel});
        lo   = PW'(lo_b);
        hi   = PW'(hi_b);
        span = PW'(hi_b - lo_b + 1);
        sz   = PW'(SIZE);
        res.vel = vel;
        res.lo  = 1'b0;
        res.hi  = 1'b0;
        if (EDGE_MODE == EDGE_WRAP) begin
            if (cand > hi) begin
                cand   = cand - span;
                res.hi = 1'b1;
            end else if (cand < lo) begin
                cand   = cand + span;
                res.lo = 1'b1;
            end
        end else begin
            if (cand + sz > hi) begin
                cand    = hi - sz;
                res.hi  = 1'b1;
                res.vel = (EDGE_MODE == EDGE_CLAMP) ? '0 : -vel;
            end else if (cand - sz < lo) begin
                cand    = lo + sz;
                res.lo  = 1'b1;
                res.vel = (EDGE_MODE == EDGE_CLAMP) ? '0 : -vel;
            end
        end
        res.pos = W'(cand);
        return res;
    endfunction

    key_dir_decode #(.NKEY(NKEY)) u_decode (
        .keycode (bus.keycode),
        .dx      (dx),
        .dy      (dy)
    );

    always_comb begin
        req_dx = (state == LOCK) ? 2'sb00 : dx;
        req_dy = (state == LOCK) ? 2'sb00 : dy;
        req_nz = (req_dx != 2'sb00) || (req_dy != 2'sb00);

        if (!req_nz || req_dx != prev_dx || req_dy != prev_dy) f_now = '0;
        else if (f_cnt == FW'(F_SAT))                          f_now = f_cnt;
        else                                                   f_now = f_cnt + 1'b1;
        spd = sat_speed(f_now);

        state_next = state;
        lock_next  = lock_cnt;
        vnx        = vel_x;
        vny        = vel_y;
        case (state)
            IDLE: begin
                vnx = '0;
                vny = '0;
                if (req_nz) begin
                    state_next = MOVE;
                    vnx        = scale(req_dx, spd);
                    vny        = scale(req_dy, spd);
                end
            end
            MOVE: begin
                if (req_nz) begin
                    vnx = scale(req_dx, spd);
                    vny = scale(req_dy, spd);
                end
            end
            default: ;
        endcase

        rx  = resolve_axis(pos_x, vnx, X_MIN, X_MAX);
        ry  = resolve_axis(pos_y, vny, Y_MIN, Y_MAX);
        hit = '0;
        hit[EDGE_L] = rx.lo;
        hit[EDGE_R] = rx.hi;
        hit[EDGE_T] = ry.lo;
        hit[EDGE_B] = ry.hi;

        // An impact (re)starts the lockout, even if already locked.
        if (EDGE_MODE != EDGE_WRAP && hit != 4'b0000) begin
            state_next = LOCK;
            lock_next  = LW'(LOCK_FRAMES);
        end else if (state == LOCK) begin
            if (lock_cnt <= LW'(1)) begin
                state_next = (rx.vel == '0 && ry.vel == '0) ? IDLE : MOVE;
                lock_next  = '0;
            end else begin
                lock_next  = lock_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            pos_x    <= W'(X_START);
            pos_y    <= W'(Y_START);
            vel_x    <= '0;
            vel_y    <= '0;
            edge_hit <= '0;
            locked   <= 1'b0;
            f_cnt    <= '0;
            prev_dx  <= 2'sb00;
            prev_dy  <= 2'sb00;
            lock_cnt <= '0;
        end else if (bus.Pause) begin
            edge_hit <= '0;
        end else begin
            state    <= state_next;
            pos_x    <= rx.pos;
            pos_y    <= ry.pos;
            vel_x    <= rx.vel;
            vel_y    <= ry.vel;
            edge_hit <= hit;
            locked   <= (state_next == LOCK);
            f_cnt    <= f_now;
            prev_dx  <= req_dx;
            prev_dy  <= req_dy;
            lock_cnt <= lock_next;
        end
    end

    assign bus.BallX   = pos_x;
    assign bus.BallY   = pos_y;
    assign bus.BallS   = W'(SIZE);
    assign bus.VelX    = vel_x;
    assign bus.VelY    = vel_y;
    assign bus.EdgeHit = edge_hit;
    assign bus.Locked  = locked;

endmodule

// File: tb/tb_sprite_motion.sv
// Bench for sprite_motion: four instances cover bounce, wrap and clamp edge behaviour.
module tb_sprite_motion;
    import sprite_motion_pkg::*;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] vx;
        logic [9:0] vy;
        logic [3:0] hit;
        logic       lk;
    } obs_t;

    typedef struct {
        logic [15:0] kc;
        logic        pause;
        obs_t        exp;
    } vec_t;

    logic   frame_clk = 1'b0;
    logic   Reset_n   = 1'b0;
    int     n_checks  = 0;
    int     n_err     = 0;
    vec_t   tbl[$];
    obs_t   exp_q[$];

    always #5 frame_clk = ~frame_clk;

    sprite_motion_if #(.W(10), .NKEY(2)) if0 ();
    sprite_motion_if #(.W(10), .NKEY(2)) if1 ();
    sprite_motion_if #(.W(10), .NKEY(2)) if2 ();
    sprite_motion_if #(.W(10), .NKEY(2)) if3 ();

    sprite_motion u_dut0 (.frame_clk(frame_clk), .Reset_n(Reset_n), .bus(if0));
    sprite_motion #(.X_START(630)) u_dut1 (.frame_clk(frame_clk), .Reset_n(Reset_n), .bus(if1));
    sprite_motion #(.X_START(638), .EDGE_MODE(EDGE_WRAP)) u_dut2 (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .bus(if2));
    sprite_motion #(.X_START(6), .EDGE_MODE(EDGE_CLAMP)) u_dut3 (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .bus(if3));

    function automatic obs_t mk(input int x, input int y, input int vx, input int vy,
                                input logic [3:0] hit, input logic lk);
        obs_t o;
        o.x = 10'(x); o.y = 10'(y); o.vx = 10'(vx); o.vy = 10'(vy);
        o.hit = hit; o.lk = lk;
        return o;
    endfunction

    function automatic obs_t get_obs(input int sel);
        obs_t o;
        case (sel)
            0:       o = {if0.BallX, if0.BallY, if0.VelX, if0.VelY, if0.EdgeHit, if0.Locked};
            1:       o = {if1.BallX, if1.BallY, if1.VelX, if1.VelY, if1.EdgeHit, if1.Locked};
            2:       o = {if2.BallX, if2.BallY, if2.VelX, if2.VelY, if2.EdgeHit, if2.Locked};
            default: o = {if3.BallX, if3.BallY, if3.VelX, if3.VelY, if3.EdgeHit, if3.Locked};
        endcase
        return o;
    endfunction

    task automatic set_in(input int sel, input logic [15:0] kc, input logic p);
        case (sel)
            0:       begin if0.keycode = kc; if0.Pause = p; end
            1:       begin if1.keycode = kc; if1.Pause = p; end
            2:       begin if2.keycode = kc; if2.Pause = p; end
            default: begin if3.keycode = kc; if3.Pause = p; end
        endcase
    endtask

    task automatic check(input string name, input int idx, input obs_t got, input obs_t exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got x=%0d y=%0d vx=%0d vy=%0d hit=%b lk=%b, need x=%0d y=%0d vx=%0d vy=%0d hit=%b lk=%b",
                     name, idx, got.x, got.y, $signed(got.vx), $signed(got.vy), got.hit, got.lk,
                     exp.x, exp.y, $signed(exp.vx), $signed(exp.vy), exp.hit, exp.lk);
        end
    endtask

    task automatic add(input logic [15:0] kc, input logic p, input obs_t e);
        vec_t v;
        v.kc = kc; v.pause = p; v.exp = e;
        tbl.push_back(v);
    endtask

    // Applies the queued vectors to one instance, one frame each; clears the table.
    task automatic run_tbl(input int sel, input string name);
        obs_t got, exp;
        for (int i = 0; i < tbl.size(); i++) begin
            set_in(sel, tbl[i].kc, tbl[i].pause);
            exp_q.push_back(tbl[i].exp);
            @(posedge frame_clk);
            #1;
            got = get_obs(sel);
            exp = exp_q.pop_front();
            check(name, i, got, exp);
        end
        tbl.delete();
    endtask

    task automatic do_reset();
        for (int s = 0; s < 4; s++) set_in(s, 16'h0000, 1'b0);
        Reset_n = 1'b0;
        #2;
        Reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   x, v;
        obs_t got;
        for (int s = 0; s < 4; s++) set_in(s, 16'h0000, 1'b0);
        @(posedge frame_clk);
        #1;
        do_reset();
        check("reset0", 0, get_obs(0), mk(320, 240, 0, 0, 4'b0000, 1'b0));
        check("reset1", 0, get_obs(1), mk(630, 240, 0, 0, 4'b0000, 1'b0));
        check("reset2", 0, get_obs(2), mk(638, 240, 0, 0, 4'b0000, 1'b0));
        check("reset3", 0, get_obs(3), mk(6,   240, 0, 0, 4'b0000, 1'b0));

        // Hold D for 20 frames: speed steps up every 8 frames.
        @(posedge frame_clk); #1;
        x = 320;
        for (int i = 0; i < 20; i++) begin
            v = 1 + i / 8;
            x = x + v;
            add(16'h0007, 1'b0, mk(x, 240, v, 0, 4'b0000, 1'b0));
        end
        run_tbl(0, "accel");
        got = get_obs(0);
        n_checks++;
        if (got.x !== 10'd356) begin
            n_err++;
            $display("FAIL accel_final: BallX=%0d need 356", got.x);
        end

        // Cancelling keys, diagonal, pause hold.
        do_reset();
        add(16'h0704, 1'b0, mk(320, 240, 0, 0, 4'b0000, 1'b0));
        add(16'h1A07, 1'b0, mk(321, 239, 1, -1, 4'b0000, 1'b0));
        for (int i = 0; i < 3; i++) add(16'h1A07, 1'b1, mk(321, 239, 1, -1, 4'b0000, 1'b0));
        add(16'h1A07, 1'b0, mk(322, 238, 1, -1, 4'b0000, 1'b0));
        run_tbl(0, "diag_pause");

        // Right-edge bounce, lockout ignoring D, then keys honoured again.
        do_reset();
        add(16'h0007, 1'b0, mk(631, 240, 1, 0, 4'b0000, 1'b0));
        for (int i = 0; i < 4; i++) add(16'h0000, 1'b0, mk(632 + i, 240, 1, 0, 4'b0000, 1'b0));
        add(16'h0000, 1'b0, mk(635, 240, -1, 0, 4'b0010, 1'b1));
        add(16'h0007, 1'b0, mk(634, 240, -1, 0, 4'b0000, 1'b1));
        add(16'h0007, 1'b0, mk(633, 240, -1, 0, 4'b0000, 1'b1));
        add(16'h0007, 1'b0, mk(632, 240, -1, 0, 4'b0000, 1'b1));
        add(16'h0007, 1'b0, mk(631, 240, -1, 0, 4'b0000, 1'b0));
        add(16'h0007, 1'b0, mk(632, 240, 1, 0, 4'b0000, 1'b0));
        run_tbl(1, "bounce");

        // Asynchronous reset while locked between edges.
        do_reset();
        add(16'h0007, 1'b0, mk(631, 240, 1, 0, 4'b0000, 1'b0));
        for (int i = 0; i < 4; i++) add(16'h0000, 1'b0, mk(632 + i, 240, 1, 0, 4'b0000, 1'b0));
        add(16'h0000, 1'b0, mk(635, 240, -1, 0, 4'b0010, 1'b1));
        add(16'h0000, 1'b0, mk(634, 240, -1, 0, 4'b0000, 1'b1));
        run_tbl(1, "prelock");
        #2;
        Reset_n = 1'b0;
        #1;
        check("async_reset", 0, get_obs(1), mk(630, 240, 0, 0, 4'b0000, 1'b0));
        #1;
        Reset_n = 1'b1;
        add(16'h0000, 1'b0, mk(630, 240, 0, 0, 4'b0000, 1'b0));
        add(16'h0007, 1'b0, mk(631, 240, 1, 0, 4'b0000, 1'b0));
        run_tbl(1, "post_reset");

        // Wrap: crossing the right bound re-enters at the left, no lockout.
        do_reset();
        add(16'h0007, 1'b0, mk(639, 240, 1, 0, 4'b0000, 1'b0));
        add(16'h0007, 1'b0, mk(0,   240, 1, 0, 4'b0010, 1'b0));
        add(16'h0007, 1'b0, mk(1,   240, 1, 0, 4'b0000, 1'b0));
        run_tbl(2, "wrap");

        // Clamp at the left bound, lockout with A still held, then back to idle.
        do_reset();
        add(16'h0004, 1'b0, mk(5, 240, -1, 0, 4'b0000, 1'b0));
        add(16'h0004, 1'b0, mk(4, 240, -1, 0, 4'b0000, 1'b0));
        add(16'h0004, 1'b0, mk(4, 240, 0, 0, 4'b0001, 1'b1));
        for (int i = 0; i < 3; i++) add(16'h0004, 1'b0, mk(4, 240, 0, 0, 4'b0000, 1'b1));
        add(16'h0004, 1'b0, mk(4, 240, 0, 0, 4'b0000, 1'b0));
        add(16'h0000, 1'b0, mk(4, 240, 0, 0, 4'b0000, 1'b0));
        add(16'h0000, 1'b0, mk(4, 240, 0, 0, 4'b0000, 1'b0));
        run_tbl(3, "clamp");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
